memory_arbiter: RTL and testbench

Shares the single memory access port between the three RV32 requesters: instruction fetch, load unit and store unit. It accepts one request at a time with a valid/ready handshake and issues it to memory, holding it through memory backpressure. It then waits for the memory response and routes it back to the owning requester. Sits between fetch/load/store and the memory model; one outstanding transaction maximum.

---
 rtl/memory_arbiter_pkg.sv | 23 ++
 rtl/memory_arbiter_grant_select.sv | 49 ++++
 rtl/memory_arbiter.sv | 175 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the fetch/load/store memory arbiter.
// Owner ids double as bit positions in the one-hot grant vector.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_FETCH = 2'd0,
    OWNER_LOAD  = 2'd1,
    OWNER_STORE = 2'd2
  } owner_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam int DEFAULT_STARVE_LIMIT = 4;

  function automatic owner_e grant_to_owner(input logic [2:0] grant);
    if (grant[OWNER_STORE])     return OWNER_STORE;
    else if (grant[OWNER_LOAD]) return OWNER_LOAD;
    else                        return OWNER_FETCH;
  endfunction

endpackage

// File: rtl/memory_arbiter_grant_select.sv
// Fixed-priority grant (store > load > fetch) with an aging counter that
// forces fetch to win after STARVE_LIMIT consecutive lost arbitrations.
module arbiter_grant_select
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_fetch_valid,
  input  logic       i_load_valid,
  input  logic       i_store_valid,
  input  logic       i_accept,
  output logic [2:0] o_grant
);

  localparam int AGE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] r_age;
  logic             w_starved;
  logic [2:0]       w_grant;

  assign w_starved = (STARVE_LIMIT != 0) && (r_age >= AGE_LIMIT);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_grant = '0;
    if (w_starved && i_fetch_valid) w_grant[OWNER_FETCH] = 1'b1;
    else if (i_store_valid)         w_grant[OWNER_STORE] = 1'b1;
    else if (i_load_valid)          w_grant[OWNER_LOAD]  = 1'b1;
    else if (i_fetch_valid)         w_grant[OWNER_FETCH] = 1'b1;
  end

  assign o_grant = w_grant;

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_age <= '0;
    end else if (i_accept) begin
      if (w_grant[OWNER_FETCH])
        r_age <= '0;
      else if (i_fetch_valid && (r_age < AGE_LIMIT))
        r_age <= r_age + AGE_W'(1);
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch, load
// and store; owns the IDLE/ISSUE/WAIT FSM, request latches and response routing.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fetch_req_valid,
  output logic                    fetch_req_ready,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr,
  output logic                    fetch_resp_valid,
  output logic [DATA_WIDTH-1:0]   fetch_resp_data,
  input  logic                    load_req_valid,
  output logic                    load_req_ready,
  input  logic [ADDR_WIDTH-1:0]   load_addr,
  output logic                    load_resp_valid,
  output logic [DATA_WIDTH-1:0]   load_resp_data,
  input  logic                    store_req_valid,
  output logic                    store_req_ready,
  input  logic [ADDR_WIDTH-1:0]   store_addr,
  input  logic [DATA_WIDTH-1:0]   store_wdata,
  input  logic [DATA_WIDTH/8-1:0] store_wstrb,
  output logic                    store_done,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic                    protocol_error
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [1:0]            r_state;
  owner_e                r_owner;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_we;

  logic                  r_fetch_resp_valid;
  logic [DATA_WIDTH-1:0] r_fetch_resp_data;
  logic                  r_load_resp_valid;
  logic [DATA_WIDTH-1:0] r_load_resp_data;
  logic                  r_store_done;
  logic                  r_protocol_error;

  logic                  w_any_valid;
  logic                  w_accept;
  logic [2:0]            w_grant;
  owner_e                w_owner;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [STRB_W-1:0]     w_sel_wstrb;
  logic                  w_sel_we;

  assign w_any_valid = fetch_req_valid | load_req_valid | store_req_valid;
  // Ready is combinational, so it is also gated by reset to keep outputs at 0.
  assign w_accept    = (r_state == ST_IDLE) && w_any_valid && !reset;

  arbiter_grant_select #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant_select (
    .clock         (clock),
    .reset         (reset),
    .i_fetch_valid (fetch_req_valid),
    .i_load_valid  (load_req_valid),
    .i_store_valid (store_req_valid),
    .i_accept      (w_accept),
    .o_grant       (w_grant)
  );

  assign w_owner = grant_to_owner(w_grant);

  always_comb begin
    w_sel_addr  = fetch_addr;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    w_sel_we    = 1'b0;
    case (w_owner)
      OWNER_LOAD: w_sel_addr = load_addr;
      OWNER_STORE: begin
        w_sel_addr  = store_addr;
        w_sel_wdata = store_wdata;
        w_sel_wstrb = store_wstrb;
        w_sel_we    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= OWNER_FETCH;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_we    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner <= w_owner;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_wstrb <= w_sel_wstrb;
            r_we    <= w_sel_we;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: if (mem_req_ready) r_state <= ST_WAIT;
        ST_WAIT:  if (mem_rsp_valid) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Response pulses last one cycle; data registers of non-owners hold their value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_resp_valid <= 1'b0;
      r_fetch_resp_data  <= '0;
      r_load_resp_valid  <= 1'b0;
      r_load_resp_data   <= '0;
      r_store_done       <= 1'b0;
      r_protocol_error   <= 1'b0;
    end else begin
      r_fetch_resp_valid <= 1'b0;
      r_load_resp_valid  <= 1'b0;
      r_store_done       <= 1'b0;
      if (mem_rsp_valid && (r_state != ST_WAIT))
        r_protocol_error <= 1'b1;
      if ((r_state == ST_WAIT) && mem_rsp_valid) begin
        case (r_owner)
          OWNER_FETCH: begin
            r_fetch_resp_data  <= mem_rsp_data;
            r_fetch_resp_valid <= 1'b1;
          end
          OWNER_LOAD: begin
            r_load_resp_data  <= mem_rsp_data;
            r_load_resp_valid <= 1'b1;
          end
          OWNER_STORE: r_store_done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign fetch_req_ready  = w_accept & w_grant[OWNER_FETCH];
  assign load_req_ready   = w_accept & w_grant[OWNER_LOAD];
  assign store_req_ready  = w_accept & w_grant[OWNER_STORE];

  assign mem_req_valid    = (r_state == ST_ISSUE);
  assign mem_we           = r_we;
  assign mem_addr         = r_addr;
  assign mem_wdata        = r_wdata;
  assign mem_wstrb        = r_wstrb;

  assign fetch_resp_valid = r_fetch_resp_valid;
  assign fetch_resp_data  = r_fetch_resp_data;
  assign load_resp_valid  = r_load_resp_valid;
  assign load_resp_data   = r_load_resp_data;
  assign store_done       = r_store_done;
  assign protocol_error   = r_protocol_error;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: responses are predicted into a scoreboard
// queue when the memory reply is driven and retired when a pulse appears.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req_valid = 1'b0, load_req_valid = 1'b0, store_req_valid = 1'b0;
  logic        fetch_req_ready, load_req_ready, store_req_ready;
  logic [31:0] fetch_addr = '0, load_addr = '0, store_addr = '0, store_wdata = '0;
  logic [3:0]  store_wstrb = '0;
  logic        fetch_resp_valid, load_resp_valid, store_done;
  logic [31:0] fetch_resp_data, load_resp_data;
  logic        mem_req_valid, mem_we;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        protocol_error;

  typedef struct {
    owner_e      owner;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  memory_arbiter #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .STARVE_LIMIT (2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .fetch_req_valid  (fetch_req_valid),
    .fetch_req_ready  (fetch_req_ready),
    .fetch_addr       (fetch_addr),
    .fetch_resp_valid (fetch_resp_valid),
    .fetch_resp_data  (fetch_resp_data),
    .load_req_valid   (load_req_valid),
    .load_req_ready   (load_req_ready),
    .load_addr        (load_addr),
    .load_resp_valid  (load_resp_valid),
    .load_resp_data   (load_resp_data),
    .store_req_valid  (store_req_valid),
    .store_req_ready  (store_req_ready),
    .store_addr       (store_addr),
    .store_wdata      (store_wdata),
    .store_wstrb      (store_wstrb),
    .store_done       (store_done),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_wstrb        (mem_wstrb),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data),
    .protocol_error   (protocol_error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] onehot(input owner_e o);
    case (o)
      OWNER_FETCH: return 3'b100;
      OWNER_LOAD:  return 3'b010;
      default:     return 3'b001;
    endcase
  endfunction

  // Retire one scoreboard entry per response pulse; vector order is {fetch, load, store}.
  always @(negedge clock) begin
    if (!reset && (fetch_resp_valid || load_resp_valid || store_done)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {61'd0, fetch_resp_valid, load_resp_valid, store_done}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_owner", {61'd0, fetch_resp_valid, load_resp_valid, store_done}, {61'd0, onehot(e.owner)});
        if (e.owner == OWNER_FETCH) check("fetch_resp_data", fetch_resp_data, e.data);
        if (e.owner == OWNER_LOAD)  check("load_resp_data", load_resp_data, e.data);
      end
    end
  end

  // Called at #1 after a negedge in IDLE with requests already driven.
  task automatic serve(input owner_e own, input logic [31:0] addr, input logic we,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic [31:0] rdata, input int stall, input int gap,
                       input bit drop);
    exp_t e;
    check("req_ready", {61'd0, fetch_req_ready, load_req_ready, store_req_ready}, {61'd0, onehot(own)});
    for (int k = 0; k <= stall; k++) begin
      @(negedge clock);
      if (k == 0 && drop) begin
        case (own)
          OWNER_FETCH: fetch_req_valid = 1'b0;
          OWNER_LOAD:  load_req_valid  = 1'b0;
          default:     store_req_valid = 1'b0;
        endcase
      end
      mem_req_ready = (k == stall);
      #1;
      check("mem_req_valid", mem_req_valid, 1);
      check("mem_addr", mem_addr, addr);
      check("mem_we", mem_we, we);
      check("mem_wstrb", mem_wstrb, wstrb);
      if (we) check("mem_wdata", mem_wdata, wdata);
      check("ready_busy", {61'd0, fetch_req_ready, load_req_ready, store_req_ready}, 64'd0);
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clock);
      #1;
      check("wait_no_req", mem_req_valid, 0);
    end
    @(negedge clock);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rdata;
    e.owner = own;
    e.data  = rdata;
    sb_q.push_back(e);
    #1;
    check("wait_no_req", mem_req_valid, 0);
    @(negedge clock);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    #1;
    check("rst_ready", {61'd0, fetch_req_ready, load_req_ready, store_req_ready}, 64'd0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_protocol_error", protocol_error, 0);
    check("rst_fetch_resp_data", fetch_resp_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(negedge clock);
    reset = 1'b0;

    // Fetch only; response two cycles after issue, pulse at t4
    @(negedge clock);
    fetch_req_valid = 1'b1;
    fetch_addr      = 32'h0000_0010;
    #1;
    serve(OWNER_FETCH, 32'h10, 1'b0, 32'h0, 4'h0, 32'h0000_0013, 0, 1, 1'b1);
    check("t1_fetch_pulse", fetch_resp_valid, 1);
    check("t1_fetch_data", fetch_resp_data, 32'h13);
    @(negedge clock);
    #1;
    check("t1_pulse_one_cycle", fetch_resp_valid, 0);

    // All three valid: store, then load, then fetch
    @(negedge clock);
    store_req_valid = 1'b1; store_addr = 32'h100; store_wdata = 32'hDEAD_BEEF; store_wstrb = 4'hF;
    load_req_valid  = 1'b1; load_addr  = 32'h200;
    fetch_req_valid = 1'b1; fetch_addr = 32'h30;
    #1;
    serve(OWNER_STORE, 32'h100, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 0, 1'b1);
    serve(OWNER_LOAD, 32'h200, 1'b0, 32'h0, 4'h0, 32'h1111_2222, 0, 0, 1'b1);
    serve(OWNER_FETCH, 32'h30, 1'b0, 32'h0, 4'h0, 32'h0000_0033, 0, 0, 1'b1);

    // Aging with limit 2: load, load, fetch, then load again
    @(negedge clock);
    load_req_valid  = 1'b1; load_addr  = 32'h400;
    fetch_req_valid = 1'b1; fetch_addr = 32'h40;
    #1;
    serve(OWNER_LOAD, 32'h400, 1'b0, 32'h0, 4'h0, 32'hA000_0001, 0, 0, 1'b0);
    serve(OWNER_LOAD, 32'h400, 1'b0, 32'h0, 4'h0, 32'hA000_0002, 0, 0, 1'b0);
    serve(OWNER_FETCH, 32'h40, 1'b0, 32'h0, 4'h0, 32'h0000_0fe7, 0, 0, 1'b0);
    serve(OWNER_LOAD, 32'h400, 1'b0, 32'h0, 4'h0, 32'hA000_0003, 0, 0, 1'b0);
    load_req_valid  = 1'b0;
    fetch_req_valid = 1'b0;

    // Memory backpressure: three stalled cycles then one handshake
    @(negedge clock);
    load_req_valid = 1'b1; load_addr = 32'h44;
    #1;
    serve(OWNER_LOAD, 32'h44, 1'b0, 32'h0, 4'h0, 32'h5555_AAAA, 3, 0, 1'b1);

    // Stray response in IDLE
    @(negedge clock);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0BAD_0BAD;
    @(negedge clock);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    #1;
    check("perr_set", protocol_error, 1);
    check("perr_fetch_data_hold", fetch_resp_data, 32'h0000_0fe7);
    check("perr_load_data_hold", load_resp_data, 32'h5555_AAAA);
    repeat (3) @(negedge clock);
    #1;
    check("perr_sticky", protocol_error, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("perr_cleared", protocol_error, 0);
    @(negedge clock);
    reset = 1'b0;

    // Reset while a load waits for its response
    @(negedge clock);
    load_req_valid = 1'b1; load_addr = 32'h80;
    #1;
    check("abort_ready", {61'd0, fetch_req_ready, load_req_ready, store_req_ready}, 64'b010);
    @(negedge clock);
    load_req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_mem_req_valid", mem_req_valid, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_mem_we", mem_we, 0);
    check("abort_mem_wdata", mem_wdata, 0);
    check("abort_mem_wstrb", mem_wstrb, 0);
    check("abort_pulses", {61'd0, fetch_resp_valid, load_resp_valid, store_done}, 64'd0);
    check("abort_load_data", load_resp_data, 0);
    check("abort_fetch_data", fetch_resp_data, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    fetch_req_valid = 1'b1; fetch_addr = 32'h20;
    #1;
    serve(OWNER_FETCH, 32'h20, 1'b0, 32'h0, 4'h0, 32'h0010_0093, 0, 1, 1'b1);
    check("post_abort_fetch_data", fetch_resp_data, 32'h0010_0093);

    repeat (2) @(negedge clock);
    #1;
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
